// File: rtl/sdio_tx_packer.sv
// Packs 8/16/32-bit uDMA TX elements little-endian into 32-bit words for the SDIO TX path.
// A transfer moves exactly len_bytes_i bytes; the final word is zero-padded.
module sdio_tx_packer #(
  parameter int LEN_WIDTH = 19
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clr_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_bytes_i,
  input  logic [31:0]          in_data_i,
  input  logic [1:0]           in_size_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [31:0]          out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    FLUSH,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [63:0]          acc;
  logic [63:0]          acc_nxt;
  logic [3:0]           fill;
  logic [3:0]           fill_nxt;
  logic [LEN_WIDTH-1:0] rem;
  logic [LEN_WIDTH-1:0] rem_nxt;

  logic [2:0]           size_bytes;
  logic [2:0]           n_bytes;
  logic [3:0]           n_acc;
  logic [3:0]           moved;
  logic [31:0]          in_mask;
  logic [31:0]          out_mask;
  logic [63:0]          acc_wr;
  logic [31:0]          move_data;
  logic                 accept;
  logic                 out_free;
  logic                 move;

  always_comb begin
    case (in_size_i)
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
    // A final element longer than the remaining count is truncated.
    n_bytes = (rem < LEN_WIDTH'(size_bytes)) ? rem[2:0] : size_bytes;

    in_mask  = '0;
    out_mask = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (b < 32'(n_bytes)) in_mask[8*b +: 8] = 8'hFF;
      if (b < 32'(fill))    out_mask[8*b +: 8] = 8'hFF;
    end

    accept   = in_valid_i & in_ready_o;
    out_free = ~out_valid_o | out_ready_i;
    move     = out_free & (((state == PACK) & (fill >= 4'd4)) |
                           ((state == FLUSH) & (fill != 4'd0)));

    n_acc     = accept ? {1'b0, n_bytes} : 4'd0;
    moved     = move ? ((fill > 4'd4) ? 4'd4 : fill) : 4'd0;
    move_data = acc[31:0] & out_mask;

    acc_wr   = accept ? (acc | (64'(in_data_i & in_mask) << {fill, 3'b000})) : acc;
    acc_nxt  = move ? (acc_wr >> 32) : acc_wr;
    fill_nxt = fill + n_acc - moved;
    rem_nxt  = rem - LEN_WIDTH'(n_acc);

    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          rem_nxt   = len_bytes_i;
          state_nxt = (len_bytes_i == '0) ? DONE : PACK;
        end
      end
      PACK:    if (rem == '0) state_nxt = FLUSH;
      FLUSH:   if ((fill == 4'd0) && out_free) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake/status outputs are registered from next-state values so they
  // match what a combinational decode of the current state would give.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || clr_i) begin
      state       <= IDLE;
      acc         <= '0;
      fill        <= '0;
      rem         <= '0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      fill  <= fill_nxt;
      rem   <= rem_nxt;
      if (move) begin
        out_data_o  <= move_data;
        out_valid_o <= 1'b1;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
      in_ready_o <= (state_nxt == PACK) && (fill_nxt <= 4'd4) && (rem_nxt != '0);
      busy_o     <= (state_nxt != IDLE);
      done_o     <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_sdio_tx_packer.sv
// Directed bench for sdio_tx_packer: byte-stream model per transfer plus a per-cycle checker.
module tb_sdio_tx_packer;

  localparam int LW = 19;

  logic          clk = 1'b0;
  logic          rstn;
  logic          clr;
  logic          start;
  logic [LW-1:0] len;
  logic [31:0]   in_data;
  logic [1:0]    in_size;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  sdio_tx_packer #(.LEN_WIDTH(LW)) dut (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr), .start_i(start), .len_bytes_i(len),
    .in_data_i(in_data), .in_size_i(in_size), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] el_data [16];
  logic [1:0]  el_size [16];
  logic [31:0] exp_q [$];
  logic [7:0]  byte_q [$];

  int cur_len   = 0;
  int acc_bytes = 0;
  int done_cnt  = 0;
  int done_base = 0;
  int cyc       = 0;
  int last_hs   = 0;
  int words_now = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Inputs change 1 time unit after posedge; the checker samples at negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: concatenate element bytes, keep len of them, pad to a word boundary.
  task automatic start_xfer(input int l, input int n_el, input bit build);
    byte_q.delete();
    if (build) begin
      for (int i = 0; i < n_el; i++) begin
        int sb;
        sb = (el_size[i] == 2'd0) ? 1 : (el_size[i] == 2'd1) ? 2 : 4;
        for (int b = 0; b < sb; b++) byte_q.push_back(el_data[i][8*b +: 8]);
      end
      while (byte_q.size() > l) void'(byte_q.pop_back());
      while ((byte_q.size() % 4) != 0) byte_q.push_back(8'h00);
      for (int w = 0; w < byte_q.size() / 4; w++)
        exp_q.push_back({byte_q[4*w+3], byte_q[4*w+2], byte_q[4*w+1], byte_q[4*w]});
    end
    cur_len   = l;
    acc_bytes = 0;
    done_base = done_cnt;
    start = 1'b1;
    len   = LW'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n_el, output int taken);
    int idx = 0;
    int t = 0;
    bit acc;
    while (idx < n_el && t < 300) begin
      in_valid = 1'b1;
      in_data  = el_data[idx];
      in_size  = el_size[idx];
      acc = in_ready;
      tick();
      t++;
      if (acc) idx++;
      else if (!busy) break;
    end
    in_valid = 1'b0;
    if (t >= 300) fail("feed_budget");
    taken = idx;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == done_base && t < 300) begin
      tick();
      t++;
    end
    if (done_cnt == done_base) fail("done_timeout");
    chk("words_left", exp_q.size(), 0);
    tick();
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      cyc++;
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_word", out_data, 32'hxxxxxxxx);
        else chk("out_word", out_data, exp_q.pop_front());
        last_hs = cyc;
        words_now++;
      end
      stall_prev = out_valid && !out_ready && !clr;
      prev_data  = out_data;
      if (in_ready) chk("no_surplus", acc_bytes < cur_len, 1'b1);
      if (in_valid && in_ready && !clr) begin
        int sb;
        sb = (in_size == 2'd0) ? 1 : (in_size == 2'd1) ? 2 : 4;
        acc_bytes += (sb < cur_len - acc_bytes) ? sb : cur_len - acc_bytes;
      end
      if (done) begin
        chk("done_q_empty", exp_q.size(), 0);
        chk("done_no_valid", out_valid, 1'b0);
        if (words_now > 0) chk("done_latency", cyc, last_hs + 1);
        done_cnt++;
        words_now = 0;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  int taken;

  initial begin
    rstn = 1'b0; clr = 1'b0; start = 1'b0; len = '0;
    in_data = '0; in_size = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rstn = 1'b1;
    tick();

    // Word mode
    el_data[0] = 32'h11223344; el_size[0] = 2'd2;
    el_data[1] = 32'h55667788; el_size[1] = 2'd2;
    start_xfer(8, 2, 1'b1);
    chk("model_w0", exp_q[0], 32'h11223344);
    chk("model_w1", exp_q[1], 32'h55667788);
    chk("busy_after_start", busy, 1'b1);
    feed(2, taken);
    chk("word_taken", taken, 2);
    wait_done();

    // Byte mode, one surplus byte offered, plus a start pulse during PACK
    for (int i = 0; i < 7; i++) begin
      el_data[i] = 32'(i + 1) | 32'hDEADBE00;
      el_size[i] = 2'd0;
    end
    start_xfer(6, 7, 1'b1);
    chk("model_b0", exp_q[0], 32'h04030201);
    chk("model_b1", exp_q[1], 32'h00000605);
    fork
      feed(7, taken);
      begin
        repeat (2) tick();
        start = 1'b1; len = LW'(2);
        tick();
        start = 1'b0;
      end
    join
    chk("byte_taken", taken, 6);
    wait_done();

    // Half mode, odd length
    el_data[0] = 32'h1234AABB; el_size[0] = 2'd1;
    el_data[1] = 32'h0000CCDD; el_size[1] = 2'd1;
    el_data[2] = 32'h0000EEFF; el_size[2] = 2'd1;
    start_xfer(5, 3, 1'b1);
    chk("model_h0", exp_q[0], 32'hCCDDAABB);
    chk("model_h1", exp_q[1], 32'h000000FF);
    feed(3, taken);
    chk("half_taken", taken, 3);
    wait_done();

    // Backpressure, reserved size code treated as word
    el_data[0] = 32'hA0A1A2A3; el_size[0] = 2'd2;
    el_data[1] = 32'hB0B1B2B3; el_size[1] = 2'd3;
    el_data[2] = 32'hC0C1C2C3; el_size[2] = 2'd2;
    el_data[3] = 32'hD0D1D2D3; el_size[3] = 2'd2;
    out_ready = 1'b0;
    start_xfer(16, 4, 1'b1);
    fork
      feed(4, taken);
      begin
        repeat (10) tick();
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_accepted", acc_bytes, 12);
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_data", out_data, 32'hA0A1A2A3);
        out_ready = 1'b1;
      end
    join
    chk("bp_taken", taken, 4);
    wait_done();

    // Zero length
    start_xfer(0, 0, 1'b1);
    chk("len0_done", done, 1'b1);
    chk("len0_busy", busy, 1'b1);
    chk("len0_valid", out_valid, 1'b0);
    tick();
    chk("len0_done_pulse", done, 1'b0);
    chk("len0_idle", busy, 1'b0);
    tick();

    // Abort with a held word and three bytes in the accumulator
    for (int i = 0; i < 7; i++) begin
      el_data[i] = 32'(8'h40 + i);
      el_size[i] = 2'd0;
    end
    out_ready = 1'b0;
    start_xfer(16, 7, 1'b0);
    feed(7, taken);
    chk("clr_taken", taken, 7);
    chk("clr_pre_valid", out_valid, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_valid", out_valid, 1'b0);
    chk("clr_data", out_data, 32'h0);
    chk("clr_in_ready", in_ready, 1'b0);
    chk("clr_busy", busy, 1'b0);
    chk("clr_done", done, 1'b0);
    out_ready = 1'b1;
    tick();

    // Fresh transfer after abort
    el_data[0] = 32'hCAFEF00D; el_size[0] = 2'd2;
    el_data[1] = 32'h0BADBEEF; el_size[1] = 2'd2;
    start_xfer(8, 2, 1'b1);
    feed(2, taken);
    chk("post_clr_taken", taken, 2);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
